key_schedule_ctrl: RTL
======================

Name: key_schedule_ctrl

Overview:
- Sequential AES key-schedule controller.
- Accepts one cipher key and generates the expanded key one 32-bit word per cycle into an internal word store.
- Streams round keys 0..NR to the round pipeline over a valid/ready interface as soon as each key's four words exist.
- Replaces per-round key expansion, so 128/192/256-bit keys are handled uniformly: round keys that span two expansion iterations are assembled from the word store.

Parameters:
- KEY_BITS, 128: key size; legal values 128, 192, 256.
- NK, KEY_BITS/32: key words (4/6/8). Derived; do not override.
- NR, NK+6: number of rounds (10/12/14). Derived.
- NW, 4*(NR+1): expanded-key words (44/52/60). Derived.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- key_in  in  256  cipher key, MSB-justified; w[0]=key_in[255:224]; bits below 256-KEY_BITS ignored.
- key_valid  in  1  key_in valid.
- key_ready  out  1  high only in IDLE.
- abort  in  1  synchronous flush to IDLE.
- rk_data  out  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}.
- rk_round  out  4  round index r of rk_data.
- rk_valid  out  1  rk_data/rk_round valid.
- rk_ready  in  1  consumer accepts.
- busy  out  1  high when not IDLE.

Behaviour:
- Reset values: rk_valid=0, rk_data=0, rk_round=0, busy=0, key_ready=1 (state IDLE). Word store is not cleared.
- States:
  - IDLE -> EXPAND on key_valid&&key_ready. Store w[0..NK-1], set word index i=NK, rcon=8'h01, phase counter=0.
  - EXPAND: each cycle write w[i] = w[i-NK] ^ temp, then i++.
  - EXPAND -> DRAIN when i reaches NW.
  - DRAIN -> IDLE on the handshake of round NR.
- temp computation:
  - If i mod NK==0: temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; rcon is then doubled in GF(2^8) (x80 -> x1b).
  - Else if NK==8 and i mod NK==4: temp = SubWord(w[i-1]).
  - Else: temp = w[i-1].
  - Track i mod NK with a wrapping phase counter; no divider.
- Expansion never stalls for rk_ready. Output may also complete during EXPAND; state goes IDLE only after both the expansion and the round-NR handshake are done.
- Output register:
  - Loads round r at the clock edge after w[4r+3] has been written and the output slot is free (rk_valid=0 or handshake this cycle). It then sets rk_valid.
  - r increments on each handshake.
  - While rk_valid && !rk_ready, rk_data and rk_round hold stable.
- Timing, with the key accepted at edge E0 and rk_ready held high:
  - Round 0 valid after E1 for all key sizes.
  - AES-128: round k valid after E(4k+1); round 10 after E41.
  - AES-192: round 1 after E3; round k after E(4k-1); round 12 after E47.
  - AES-256: round 1 after E2; round k≥2 after E(4k-3); round 14 after E53.
- After the round-NR handshake: rk_valid=0 and key_ready=1 on the next cycle. A key_valid in the same cycle as the final handshake is not accepted (key_ready low); it is accepted the following cycle.
- abort:
  - Takes effect at the next edge: state IDLE, rk_valid=0, r=0.
  - Has priority over key acceptance and over a simultaneous handshake; that handshake is discarded.
- reset_n low mid-operation: immediate return to reset values. No partial round keys are emitted afterwards.
- rk_round width is 4; maximum value 14.

Test Plan:
- AES-128, key 2b7e1516_28aed2a6_abf71588_09cf4f3c, rk_ready=1:
  - round 1 = a0fafe17_88542cb1_23a33939_2a6c7605;
  - round 10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6, valid after E41;
  - key_ready high the following cycle.
- AES-192, key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b:
  - round 1 = 62f8ead2_522c6b7b_fe0c91f7_2402f5a5 (spans key and expanded words);
  - last word of round 12 = 01002202.
- AES-256, key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4:
  - round 2 = 9ba35411_8e6925af_a51a8b5f_2067fcde;
  - round 3 first word = a8b09c1a (SubWord-only path);
  - round 14 last word = 706c631e.
- Backpressure, AES-128: hold rk_ready=0 for 50 cycles after key acceptance.
  - rk_valid=1 with round 0 and rk_data stable throughout.
  - Then with rk_ready=1, rounds 1..10 stream one per cycle, values as in the first scenario.
- Abort, AES-256: assert abort during round 5's handshake cycle.
  - Next cycle: rk_valid=0, busy=0, key_ready=1.
  - A new key then yields round 0 after E1.
- Reset: pull reset_n low mid-EXPAND.
  - All outputs take reset values asynchronously.
  - Re-running the AES-128 vector yields identical round keys.

Source files
------------

// File: rtl/key_schedule_ctrl.sv
// AES key-schedule controller: expands one cipher key a word per cycle into a
// word store and streams round keys 0..NR over a valid/ready interface as soon
// as each round key's four words exist.
module key_schedule_ctrl #(
  parameter int KEY_BITS = 128
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [255:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         abort,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam int IW = $clog2(NW + 1);

  localparam logic [IW-1:0] NK_I   = IW'(NK);
  localparam logic [IW-1:0] LAST_I = IW'(NW - 1);
  localparam logic [3:0]    NR_R   = 4'(NR);
  localparam logic [2:0]    NK_M1  = 3'(NK - 1);

  typedef enum logic [1:0] {IDLE, EXPAND, DRAIN} state_t;

  state_t        state, state_next;
  logic [31:0]   w [0:NW-1];
  logic [IW-1:0] i;          // index of the next word to write
  logic [2:0]    ph;         // i mod NK, kept as a wrapping counter
  logic [7:0]    rcon;
  logic [3:0]    nr_cnt;     // next round to load into the output register
  logic          accept, expand_en, handshake, final_hs, load;
  logic [31:0]   prev_word, temp, new_word;
  logic [IW-1:0] base;
  logic [127:0]  round_words;
  logic          key_unused;

  // Key bits below 256-KEY_BITS are don't-care for shorter keys.
  assign key_unused = ^key_in;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv, sq;
    inv = 8'h01;
    sq  = a;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  assign accept    = key_valid && (state == IDLE) && !abort;
  assign expand_en = (state == EXPAND) && !abort;
  assign handshake = rk_valid && rk_ready;
  assign final_hs  = handshake && (rk_round == NR_R);
  // A round is ready once all of its words are in the store (i >= 4r+4).
  assign load = (state != IDLE) && !abort && (nr_cnt <= NR_R) &&
                (IW'(nr_cnt) < (i >> 2)) && (!rk_valid || rk_ready);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and status outputs; abort flushes to IDLE from any busy state.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    key_ready  = (state == IDLE);
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (accept) state_next = EXPAND;
      EXPAND:  if (abort) state_next = IDLE;
               else if (i == LAST_I) state_next = DRAIN;
      DRAIN:   if (abort || final_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next expanded word: w[i] = w[i-NK] ^ temp, temp chosen by i mod NK.
  always_comb begin
    prev_word = w[i - IW'(1)];
    temp      = prev_word;
    if (ph == 3'd0)
      temp = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h0};
    else if (NK == 8 && ph == 3'd4)
      temp = sub_word(prev_word);
    new_word = w[i - NK_I] ^ temp;
  end

  // Gather the four words of the next round key from the store.
  always_comb begin
    base        = IW'({nr_cnt, 2'b00});
    round_words = {w[base], w[base + IW'(1)], w[base + IW'(2)], w[base + IW'(3)]};
  end

  // Word store: key words on acceptance, one expanded word per EXPAND cycle.
  // NOTE: the word store has no reset; it is always rewritten from the key before it is read.
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int j = 0; j < NK; j++) w[j] <= key_in[255 - 32*j -: 32];
    end else if (expand_en) begin
      w[i] <= new_word;
    end
  end

  // Expansion counters and the round-key output register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      i        <= '0;
      ph       <= '0;
      rcon     <= 8'h01;
      nr_cnt   <= '0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_round <= '0;
    end else if (abort) begin
      // Any handshake in this cycle is discarded.
      rk_valid <= 1'b0;
      rk_round <= '0;
      nr_cnt   <= '0;
    end else begin
      if (accept) begin
        i      <= NK_I;
        ph     <= '0;
        rcon   <= 8'h01;
        nr_cnt <= '0;
      end else if (expand_en) begin
        i  <= i + IW'(1);
        ph <= (ph == NK_M1) ? 3'd0 : ph + 3'd1;
        if (ph == 3'd0) rcon <= xtime(rcon);
      end
      if (load) begin
        rk_data  <= round_words;
        rk_round <= nr_cnt;
        rk_valid <= 1'b1;
        nr_cnt   <= nr_cnt + 4'd1;
      end else if (handshake) begin
        rk_valid <= 1'b0;
      end
    end
  end

endmodule
